reg_file_mp: RTL and testbench

Parametrised multi-port register file for the next-generation pipeline core. It replaces the fixed 2-read/1-write, 32x32 file. It adds:
- N registered read ports
- two prioritised write ports (ALU writeback and load writeback)
- optional write-to-read bypass
- a per-register pending scoreboard for hazard detection in decode

All state updates and read captures occur on the rising edge of clock.

---
 rtl/reg_file_pkg.sv | 32 +++
 rtl/rf_read_port.sv | 62 ++++++
 rtl/reg_file_mp.sv | 94 +++++++++
 tb/tb_reg_file_mp.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, write-pick type and helper for reg_file_mp.
// Ports: none (package).
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_RD     = 2;
  localparam bit DEF_ZERO_REG   = 1'b1;
  localparam bit DEF_BYPASS     = 1'b1;

  localparam logic [DEF_DATA_WIDTH-1:0] ZERO_VALUE = '0;

  // en: some write hits this address; sel1: take wr1 data
  typedef struct packed {
    logic en;
    logic sel1;
  } wr_pick_t;

  // Resolves the two write ports for one address; wr1 wins a tie.
  function automatic wr_pick_t wr_pick(
    input logic en0,
    input logic hit0,
    input logic en1,
    input logic hit1
  );
    wr_pick_t r;
    r.sel1 = en1 && hit1;
    r.en   = r.sel1 || (en0 && hit0);
    return r;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port (mux, bypass, r0 force, pending).
// Ports: clock/reset, rd_en/rd_addr in; storage, pending, write ports in; rd_data/rd_valid/rd_pending out.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit ZERO_REG   = DEF_ZERO_REG,
  parameter bit BYPASS     = DEF_BYPASS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
  input  logic [2**ADDR_WIDTH-1:0] pend,
  input  logic                  wr0_en,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_pending
);

  wr_pick_t              pk;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  pend_n;

  always_comb begin
    pk = wr_pick(wr0_en, wr0_addr == rd_addr,
                 wr1_en, wr1_addr == rd_addr);
    data_n = mem[rd_addr];
    pend_n = pend[rd_addr];
    // A same-cycle write both supplies the data and retires the producer.
    if (BYPASS && pk.en) begin
      data_n = pk.sel1 ? wr1_data : wr0_data;
      pend_n = 1'b0;
    end
    if (ZERO_REG && rd_addr == '0) begin
      data_n = DATA_WIDTH'(ZERO_VALUE);
      pend_n = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data    <= data_n;
        rd_pending <= pend_n;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read, two-write register file with pending scoreboard.
// Ports: clock, reset (sync, active-low); rd_*; wr0_*/wr1_* (wr1 wins); pend_set_*.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter bit ZERO_REG   = DEF_ZERO_REG,
  parameter bit BYPASS     = DEF_BYPASS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_pending,
  input  logic                         wr0_en,
  input  logic [ADDR_WIDTH-1:0]        wr0_addr,
  input  logic [DATA_WIDTH-1:0]        wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_WIDTH-1:0]        wr1_addr,
  input  logic [DATA_WIDTH-1:0]        wr1_data,
  input  logic                         pend_set_en,
  input  logic [ADDR_WIDTH-1:0]        pend_set_addr
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      we;
  logic [DEPTH-1:0]      sel1;
  logic [DEPTH-1:0]      setv;
  wr_pick_t              pk;

  always_comb begin
    we   = '0;
    sel1 = '0;
    setv = '0;
    pk   = '0;
    for (int a = 0; a < DEPTH; a++) begin
      pk = wr_pick(wr0_en, wr0_addr == ADDR_WIDTH'(a),
                   wr1_en, wr1_addr == ADDR_WIDTH'(a));
      we[a]   = pk.en;
      sel1[a] = pk.sel1;
      setv[a] = pend_set_en && pend_set_addr == ADDR_WIDTH'(a);
    end
    if (ZERO_REG) begin
      we[0]   = 1'b0;
      setv[0] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      pend <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (we[a]) mem[a] <= sel1[a] ? wr1_data : wr0_data;
      end
      // A newly issued producer outranks a retiring one.
      pend <= setv | (pend & ~we);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
    ) u_port (
      .clock     (clock),
      .reset     (reset),
      .rd_en     (rd_en[i]),
      .rd_addr   (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem       (mem),
      .pend      (pend),
      .wr0_en    (wr0_en),
      .wr0_addr  (wr0_addr),
      .wr0_data  (wr0_data),
      .wr1_en    (wr1_en),
      .wr1_addr  (wr1_addr),
      .wr1_data  (wr1_data),
      .rd_data   (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid  (rd_valid[i]),
      .rd_pending(rd_pending[i])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp.
// Two instances: 4-port with bypass, 1-port without bypass.
module tb_reg_file_mp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [3:0]  rd_en;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]  rd_valid;
  logic [3:0]  rd_pending;
  logic        w0_en, w1_en, pse;
  logic [4:0]  w0_addr, w1_addr, psa;
  logic [31:0] w0_data, w1_data;
  logic        nb_en;
  logic [31:0] nb_data;
  logic        nb_valid, nb_pending;

  reg_file_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_pending(rd_pending),
    .wr0_en(w0_en), .wr0_addr(w0_addr), .wr0_data(w0_data),
    .wr1_en(w1_en), .wr1_addr(w1_addr), .wr1_data(w1_data),
    .pend_set_en(pse), .pend_set_addr(psa)
  );

  reg_file_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(1),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_nb (
    .clock(clock), .reset(reset),
    .rd_en(nb_en), .rd_addr(rd_addr[4:0]),
    .rd_data(nb_data), .rd_valid(nb_valid),
    .rd_pending(nb_pending),
    .wr0_en(w0_en), .wr0_addr(w0_addr), .wr0_data(w0_data),
    .wr1_en(w1_en), .wr1_addr(w1_addr), .wr1_data(w1_data),
    .pend_set_en(pse), .pend_set_addr(psa)
  );

  typedef struct {
    int          port;
    int          due;
    logic [31:0] d;
    logic        p;
  } exp_t;

  exp_t q[$];
  exp_t qn[$];
  exp_t e;
  exp_t en;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_pend;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops one expectation per valid read and compares.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      n_chk++;
      $display("FAIL missing_rd port%0d: got no valid, want valid at cyc %0d",
               q[0].port, q[0].due);
      void'(q.pop_front());
    end
    for (int p = 0; p < 4; p++) begin
      if (rd_valid[p]) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_rd port%0d: got valid data %h, want no read",
                   p, rd_data[p*32 +: 32]);
        end else begin
          e = q.pop_front();
          if (e.port == p && e.due == cyc &&
              rd_data[p*32 +: 32] === e.d && rd_pending[p] === e.p)
            n_pass++;
          else
            $display("FAIL rd port%0d cyc%0d: got data %h pend %b, want port%0d cyc%0d data %h pend %b",
                     p, cyc, rd_data[p*32 +: 32], rd_pending[p],
                     e.port, e.due, e.d, e.p);
        end
      end
    end
    while (qn.size() > 0 && qn[0].due < cyc) begin
      n_chk++;
      $display("FAIL missing_nb: got no valid, want valid at cyc %0d", qn[0].due);
      void'(qn.pop_front());
    end
    if (nb_valid) begin
      n_chk++;
      if (qn.size() == 0) begin
        $display("FAIL unexpected_nb: got valid data %h, want no read", nb_data);
      end else begin
        en = qn.pop_front();
        if (en.due == cyc && nb_data === en.d && nb_pending === en.p)
          n_pass++;
        else
          $display("FAIL nb cyc%0d: got data %h pend %b, want cyc%0d data %h pend %b",
                   cyc, nb_data, nb_pending, en.due, en.d, en.p);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic idle();
    rd_en = '0;
    rd_addr = '0;
    w0_en = 1'b0; w0_addr = '0; w0_data = '0;
    w1_en = 1'b0; w1_addr = '0; w1_data = '0;
    pse = 1'b0; psa = '0;
    nb_en = 1'b0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    w0_en = 1'b1; w0_addr = a; w0_data = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    w1_en = 1'b1; w1_addr = a; w1_data = d;
  endtask

  task automatic pset(input logic [4:0] a);
    pse = 1'b1; psa = a;
  endtask

  task automatic rd(input int p, input logic [4:0] a,
                    input logic [31:0] d, input logic pd);
    exp_t x;
    rd_en[p] = 1'b1;
    rd_addr[p*5 +: 5] = a;
    x.port = p; x.due = cyc + 1; x.d = d; x.p = pd;
    q.push_back(x);
  endtask

  task automatic nb_rd(input logic [31:0] d, input logic pd);
    exp_t x;
    nb_en = 1'b1;
    x.port = 0; x.due = cyc + 1; x.d = d; x.p = pd;
    qn.push_back(x);
  endtask

  // Reference read: call after this cycle's writes are set up.
  task automatic rd_m(input int p, input logic [4:0] a);
    logic [31:0] d;
    logic pd;
    d = m_mem[a];
    pd = m_pend[a];
    if (w1_en && w1_addr == a) begin
      d = w1_data; pd = 1'b0;
    end else if (w0_en && w0_addr == a) begin
      d = w0_data; pd = 1'b0;
    end
    if (a == 5'd0) begin
      d = '0; pd = 1'b0;
    end
    rd(p, a, d, pd);
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      for (int a = 0; a < 32; a++) m_mem[a] = '0;
      m_pend = '0;
    end else begin
      if (w0_en) m_pend[w0_addr] = 1'b0;
      if (w1_en) m_pend[w1_addr] = 1'b0;
      if (pse) m_pend[psa] = 1'b1;
      m_pend[0] = 1'b0;
      if (w0_en && w0_addr != 5'd0) m_mem[w0_addr] = w0_data;
      if (w1_en && w1_addr != 5'd0) m_mem[w1_addr] = w1_data;
    end
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish by 200000");
    $fatal(1);
  end

  initial begin
    int base;
    idle();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(rd_valid), 32'h0);
    chk("rst_pend", 32'(rd_pending), 32'h0);
    chk("rst_data0", rd_data[31:0], 32'h0);
    chk("rst_data3", rd_data[127:96], 32'h0);
    reset = 1'b1;

    // reset wipes a written entry and an in-flight read
    wr0(5'd5, 32'hDEADBEEF);
    tick();
    reset = 1'b0;
    rd_en[0] = 1'b1;
    rd_addr[4:0] = 5'd5;
    tick();
    tick();
    chk("rst2_valid", 32'(rd_valid), 32'h0);
    reset = 1'b1;
    rd(0, 5'd5, 32'h0, 1'b0);
    tick();

    // write priority and dual writes
    wr0(5'd3, 32'h11);
    wr1(5'd3, 32'h22);
    tick();
    rd(0, 5'd3, 32'h22, 1'b0);
    tick();
    wr0(5'd4, 32'hAA);
    wr1(5'd6, 32'hBB);
    tick();
    rd(0, 5'd4, 32'hAA, 1'b0);
    rd(1, 5'd6, 32'hBB, 1'b0);
    tick();

    // bypass vs no bypass
    wr0(5'd7, 32'h5);
    tick();
    wr0(5'd7, 32'h1234);
    rd(0, 5'd7, 32'h1234, 1'b0);
    nb_rd(32'h5, 1'b0);
    tick();
    rd_addr[4:0] = 5'd7;
    nb_rd(32'h1234, 1'b0);
    tick();

    // zero register
    wr0(5'd0, 32'hFFFFFFFF);
    pset(5'd0);
    for (int p = 0; p < 4; p++) rd(p, 5'd0, 32'h0, 1'b0);
    tick();
    for (int p = 0; p < 4; p++) rd(p, 5'd0, 32'h0, 1'b0);
    tick();

    // pending scoreboard
    pset(5'd9);
    tick();
    rd(0, 5'd9, 32'h0, 1'b1);
    tick();
    wr0(5'd9, 32'h99);
    pset(5'd9);
    tick();
    rd(0, 5'd9, 32'h99, 1'b1);
    tick();
    wr1(5'd9, 32'h77);
    rd(1, 5'd9, 32'h77, 1'b0);
    tick();
    rd(0, 5'd9, 32'h77, 1'b0);
    rd(2, 5'd9, 32'h77, 1'b0);
    tick();
    tick();
    chk("hold_valid", 32'(rd_valid), 32'h0);
    chk("hold_data0", rd_data[31:0], 32'h77);
    chk("hold_data2", rd_data[95:64], 32'h77);

    // preload, then random 4-port reads against the model
    for (int a = 1; a < 32; a++) begin
      wr0(5'(a), 32'h1000_0000 + 32'(a) * 32'h0101);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) wr0(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) wr1(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 2) == 0) pset(5'($urandom_range(0, 31)));
      base = int'($urandom_range(0, 30));
      for (int p = 0; p < 4; p++) rd_m(p, 5'(((base + p * 7) % 31) + 1));
      tick();
    end

    tick();
    tick();
    chk("drain", 32'(q.size() + qn.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
